// File: rtl/bram_port_arbiter.sv
// bram_port_arbiter: shares one BRAM port between the instruction requester
// (prefetch buffer) and the data requester (load/store unit).
//
// Handshake: a requester raises *_valid with stable fields and holds it until
// its *_ready pulses for one cycle. On the BRAM side, bram_valid and the
// bram_* fields are held stable until bram_ready pulses for one cycle. Only one
// BRAM transaction is outstanding; each grant is followed by one idle bubble.
//
// Optional build macro ARB_ROUND_ROBIN_EN: when defined, contention is resolved
// by alternating owners (last-owner register) instead of data priority with a
// starvation limit.
module bram_port_arbiter #(
  parameter int XLEN         = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              imem_valid,
  input  logic [XLEN-1:0]   imem_addr,
  output logic [XLEN-1:0]   imem_rdata,
  output logic              imem_ready,
  input  logic              dmem_valid,
  input  logic [XLEN-1:0]   dmem_addr,
  input  logic [XLEN-1:0]   dmem_wdata,
  input  logic [XLEN/8-1:0] dmem_wstrb,
  output logic [XLEN-1:0]   dmem_rdata,
  output logic              dmem_ready,
  output logic              bram_valid,
  output logic              bram_instr,
  output logic [XLEN-1:0]   bram_addr,
  output logic [XLEN-1:0]   bram_wdata,
  output logic [XLEN/8-1:0] bram_wstrb,
  input  logic [XLEN-1:0]   bram_rdata,
  input  logic              bram_ready,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  state_t state;
  logic   grant_d;
  logic   grant_i;
  logic   grant_any;

`ifdef ARB_ROUND_ROBIN_EN
  // 0 = instruction port served last, 1 = data port served last
  logic last_owner;

  // Under contention serve the port that was not served last
  always_comb begin
    grant_d = 1'b0;
    if (dmem_valid && (!imem_valid || !last_owner)) grant_d = 1'b1;
  end

  // Remember the owner of every grant, including uncontended ones
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      last_owner <= 1'b0;
    end else if (grant_any) begin
      last_owner <= grant_d;
    end
  end
`else
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);
  logic [CNT_W-1:0] starve_cnt;

  // Data wins unless the instruction port has been passed over LIMIT times
  always_comb begin
    grant_d = 1'b0;
    if (dmem_valid && (!imem_valid || (starve_cnt < LIMIT))) grant_d = 1'b1;
  end

  // Count data grants that bypassed a waiting instruction request (saturating)
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      starve_cnt <= '0;
    end else if (grant_any) begin
      if (grant_d && imem_valid) begin
        if (starve_cnt != LIMIT) starve_cnt <= starve_cnt + CNT_W'(1);
      end else begin
        starve_cnt <= '0;
      end
    end
  end
`endif

  assign grant_i   = imem_valid && !grant_d;
  assign grant_any = (state == IDLE) && (grant_d || grant_i);

  // Arbitration FSM: latch the winner's fields at grant, hold until bram_ready
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      bram_valid <= 1'b0;
      bram_instr <= 1'b0;
      bram_addr  <= '0;
      bram_wdata <= '0;
      bram_wstrb <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_d) begin
            state      <= BUSY_D;
            bram_valid <= 1'b1;
            bram_instr <= 1'b0;
            bram_addr  <= dmem_addr;
            bram_wdata <= dmem_wdata;
            bram_wstrb <= dmem_wstrb;
          end else if (grant_i) begin
            state      <= BUSY_I;
            bram_valid <= 1'b1;
            bram_instr <= 1'b1;
            bram_addr  <= imem_addr;
            bram_wdata <= '0;
            bram_wstrb <= '0;
          end else begin
            bram_valid <= 1'b0;
          end
        end
        BUSY_I, BUSY_D: begin
          if (bram_ready) begin
            state      <= IDLE;
            bram_valid <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          bram_valid <= 1'b0;
        end
      endcase
    end
  end

  // Completion is routed to the current owner only; read data passes straight through
  assign imem_ready = (state == BUSY_I) && bram_ready;
  assign dmem_ready = (state == BUSY_D) && bram_ready;
  assign imem_rdata = bram_rdata;
  assign dmem_rdata = bram_rdata;
  assign dbg_state  = state;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed testbench for bram_port_arbiter with a small BRAM responder model.
module tb_bram_port_arbiter;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] KEY = 32'h5A5A_0000;

  logic              clock;
  logic              reset;
  logic              imem_valid;
  logic [XLEN-1:0]   imem_addr;
  logic [XLEN-1:0]   imem_rdata;
  logic              imem_ready;
  logic              dmem_valid;
  logic [XLEN-1:0]   dmem_addr;
  logic [XLEN-1:0]   dmem_wdata;
  logic [XLEN/8-1:0] dmem_wstrb;
  logic [XLEN-1:0]   dmem_rdata;
  logic              dmem_ready;
  logic              bram_valid;
  logic              bram_instr;
  logic [XLEN-1:0]   bram_addr;
  logic [XLEN-1:0]   bram_wdata;
  logic [XLEN/8-1:0] bram_wstrb;
  logic [XLEN-1:0]   bram_rdata;
  logic              bram_ready;
  logic [1:0]        dbg_state;

  int checks = 0;
  int errors = 0;

  bram_port_arbiter #(.XLEN(XLEN), .STARVE_LIMIT(4), .CNT_W(4)) dut (
    .clock(clock), .reset(reset),
    .imem_valid(imem_valid), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ready(imem_ready),
    .dmem_valid(dmem_valid), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
    .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
    .bram_valid(bram_valid), .bram_instr(bram_instr), .bram_addr(bram_addr), .bram_wdata(bram_wdata),
    .bram_wstrb(bram_wstrb), .bram_rdata(bram_rdata), .bram_ready(bram_ready), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // BRAM model: ready two cycles after bram_valid rises, rdata = addr ^ KEY
  logic model_en  = 1'b1;
  logic man_ready = 1'b0;
  logic mready    = 1'b0;
  int   mcnt      = 0;
  assign bram_ready = mready | man_ready;

  always @(negedge clock) begin
    if (model_en && bram_valid === 1'b1 && !mready) begin
      mcnt++;
      if (mcnt == 2) begin
        mready     = 1'b1;
        bram_rdata = bram_addr ^ KEY;
        mcnt       = 0;
      end
    end else begin
      mready = 1'b0;
      mcnt   = 0;
    end
  end

  // Monitor: ready pulse counts, grant order, idle gap before each grant
  int   cnt_i = 0;
  int   cnt_d = 0;
  int   low_run = 0;
  int   last_gap = 0;
  logic prev_valid = 1'b0;
  logic grant_q[$];
  logic [0:0] exp_q[$];

  always @(negedge clock) begin
    #3;
    if (imem_ready === 1'b1) cnt_i++;
    if (dmem_ready === 1'b1) cnt_d++;
    if (bram_valid === 1'b1) begin
      if (!prev_valid) begin
        grant_q.push_back(bram_instr);
        last_gap = low_run;
      end
      low_run = 0;
    end else begin
      low_run++;
    end
    prev_valid = bram_valid;
  end

  // driver: wait for a ready pulse on one port, bounded
  task automatic wait_ready(input bit is_i, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock); #4;
      if ((is_i ? imem_ready : dmem_ready) === 1'b1) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; imem_valid = 1'b0; imem_addr = '0; dmem_valid = 1'b0;
    dmem_addr = '0; dmem_wdata = '0; dmem_wstrb = '0; bram_rdata = '0;
    repeat (2) @(negedge clock);
    #4;
    checks++; if (bram_valid !== 1'b0) begin errors++; $display("FAIL reset_bram_valid got %b exp 0", bram_valid); end
    checks++; if (bram_instr !== 1'b0) begin errors++; $display("FAIL reset_bram_instr got %b exp 0", bram_instr); end
    checks++; if (bram_addr !== '0) begin errors++; $display("FAIL reset_bram_addr got %h exp 0", bram_addr); end
    checks++; if (bram_wdata !== '0) begin errors++; $display("FAIL reset_bram_wdata got %h exp 0", bram_wdata); end
    checks++; if (bram_wstrb !== '0) begin errors++; $display("FAIL reset_bram_wstrb got %h exp 0", bram_wstrb); end
    checks++; if (imem_ready !== 1'b0 || dmem_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got i=%b d=%b exp 0", imem_ready, dmem_ready); end
    checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", dbg_state); end
    @(negedge clock); reset = 1'b1;
    @(posedge clock); #1;
    checks++; if (dbg_state !== 2'd0 || bram_valid !== 1'b0) begin errors++; $display("FAIL post_reset_idle got state=%0d valid=%b exp 0/0", dbg_state, bram_valid); end
  endtask

  task automatic test_dmem_read();
    bit ok;
    @(negedge clock);
    cnt_i = 0; cnt_d = 0;
    dmem_valid = 1'b1; dmem_addr = 32'h40; dmem_wdata = '0; dmem_wstrb = '0;
    @(posedge clock); #1;
    checks++; if (bram_valid !== 1'b1) begin errors++; $display("FAIL rd_grant_valid got %b exp 1", bram_valid); end
    checks++; if (bram_addr !== 32'h40) begin errors++; $display("FAIL rd_grant_addr got %h exp 00000040", bram_addr); end
    checks++; if (bram_wstrb !== 4'h0 || bram_instr !== 1'b0) begin errors++; $display("FAIL rd_grant_fields got wstrb=%h instr=%b exp 0/0", bram_wstrb, bram_instr); end
    checks++; if (dbg_state !== 2'd2) begin errors++; $display("FAIL rd_state got %0d exp 2", dbg_state); end
    wait_ready(1'b0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rd_ready_timeout got none exp dmem_ready"); end
    checks++; if (dmem_rdata !== 32'h5A5A_0040) begin errors++; $display("FAIL rd_data got %h exp 5a5a0040", dmem_rdata); end
    checks++; if (imem_ready !== 1'b0) begin errors++; $display("FAIL rd_imem_ready got %b exp 0", imem_ready); end
    @(posedge clock); #1; dmem_valid = 1'b0;
    repeat (3) @(negedge clock); #4;
    checks++; if (cnt_d != 1 || cnt_i != 0) begin errors++; $display("FAIL rd_pulse_count got d=%0d i=%0d exp 1/0", cnt_d, cnt_i); end
  endtask

  task automatic test_dmem_write();
    bit got = 1'b0;
    bit stable = 1'b1;
    @(negedge clock);
    dmem_valid = 1'b1; dmem_addr = 32'h10; dmem_wdata = 32'hDEAD_BEEF; dmem_wstrb = 4'b0011;
    @(posedge clock); #1;
    checks++; if (bram_wdata !== 32'hDEAD_BEEF || bram_wstrb !== 4'b0011 || bram_addr !== 32'h10) begin
      errors++; $display("FAIL wr_grant got addr=%h wdata=%h wstrb=%h exp 00000010/deadbeef/3", bram_addr, bram_wdata, bram_wstrb);
    end
    dmem_wdata = 32'h1234_5678; dmem_wstrb = 4'hF; dmem_addr = 32'h99;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock); #4;
      if (bram_valid !== 1'b1 || bram_wdata !== 32'hDEAD_BEEF || bram_wstrb !== 4'b0011 || bram_addr !== 32'h10) stable = 1'b0;
      if (dmem_ready === 1'b1) begin got = 1'b1; break; end
    end
    checks++; if (!got) begin errors++; $display("FAIL wr_ready_timeout got none exp dmem_ready"); end
    checks++; if (!stable) begin errors++; $display("FAIL wr_stable got changed exp held deadbeef/3/10"); end
    @(posedge clock); #1; dmem_valid = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  task automatic test_back_to_back();
    bit ok;
    @(negedge clock);
    cnt_i = 0; cnt_d = 0;
    imem_valid = 1'b1; imem_addr = 32'h0;
    @(posedge clock); #1;
    checks++; if (bram_instr !== 1'b1 || bram_addr !== 32'h0 || bram_wstrb !== 4'h0 || bram_wdata !== '0) begin
      errors++; $display("FAIL i_grant got instr=%b addr=%h wstrb=%h wdata=%h exp 1/0/0/0", bram_instr, bram_addr, bram_wstrb, bram_wdata);
    end
    wait_ready(1'b1, ok);
    checks++; if (!ok) begin errors++; $display("FAIL i0_ready_timeout got none exp imem_ready"); end
    checks++; if (imem_rdata !== 32'h5A5A_0000 || dmem_ready !== 1'b0) begin errors++; $display("FAIL i0_data got %h d_ready=%b exp 5a5a0000/0", imem_rdata, dmem_ready); end
    @(posedge clock); #1; imem_addr = 32'h4;
    wait_ready(1'b1, ok);
    checks++; if (!ok) begin errors++; $display("FAIL i1_ready_timeout got none exp imem_ready"); end
    checks++; if (imem_rdata !== 32'h5A5A_0004 || bram_addr !== 32'h4) begin errors++; $display("FAIL i1_data got rdata=%h addr=%h exp 5a5a0004/00000004", imem_rdata, bram_addr); end
    checks++; if (last_gap != 1) begin errors++; $display("FAIL i_bubble got %0d exp 1", last_gap); end
    @(posedge clock); #1; imem_valid = 1'b0;
    repeat (3) @(negedge clock); #4;
    checks++; if (cnt_i != 2 || cnt_d != 0) begin errors++; $display("FAIL i_pulse_count got i=%0d d=%0d exp 2/0", cnt_i, cnt_d); end
  endtask

  task automatic test_starvation();
    @(negedge clock); reset = 1'b0;
    @(negedge clock); reset = 1'b1;
    grant_q.delete();
    exp_q.delete();
`ifdef ARB_ROUND_ROBIN_EN
    for (int i = 0; i < 10; i++) exp_q.push_back((i % 2) == 1);
`else
    for (int i = 0; i < 10; i++) exp_q.push_back((i == 4) || (i == 9));
`endif
    imem_addr = 32'h100; dmem_addr = 32'h200; dmem_wdata = '0; dmem_wstrb = '0;
    imem_valid = 1'b1; dmem_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock); #4;
      if (grant_q.size() >= 10) break;
    end
    imem_valid = 1'b0; dmem_valid = 1'b0;
    repeat (5) @(negedge clock); #4;
    checks++; if (grant_q.size() != 10) begin errors++; $display("FAIL starve_count got %0d exp 10", grant_q.size()); end
    for (int i = 0; i < 10; i++) begin
      if (i < grant_q.size()) begin
        checks++;
        if (grant_q[i] !== exp_q[i][0]) begin errors++; $display("FAIL starve_grant[%0d] got %s exp %s", i, grant_q[i] ? "I" : "D", exp_q[i][0] ? "I" : "D"); end
      end
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clock);
    cnt_d = 0; cnt_i = 0;
    model_en = 1'b0;
    dmem_valid = 1'b1; dmem_addr = 32'h80; dmem_wstrb = '0;
    @(posedge clock); #1;
    checks++; if (dbg_state !== 2'd2 || bram_valid !== 1'b1) begin errors++; $display("FAIL mid_busy got state=%0d valid=%b exp 2/1", dbg_state, bram_valid); end
    #2; reset = 1'b0; dmem_valid = 1'b0;
    #1;
    checks++; if (bram_valid !== 1'b0 || dbg_state !== 2'd0) begin errors++; $display("FAIL mid_async got valid=%b state=%0d exp 0/0", bram_valid, dbg_state); end
    @(negedge clock); reset = 1'b1;
    @(negedge clock); man_ready = 1'b1;
    #4;
    checks++; if (dmem_ready !== 1'b0) begin errors++; $display("FAIL mid_late_ready got %b exp 0", dmem_ready); end
    @(negedge clock); man_ready = 1'b0;
    repeat (2) @(negedge clock); #4;
    checks++; if (cnt_d != 0 || dbg_state !== 2'd0 || bram_valid !== 1'b0) begin
      errors++; $display("FAIL mid_after got pulses=%0d state=%0d valid=%b exp 0/0/0", cnt_d, dbg_state, bram_valid);
    end
  endtask

  task automatic test_idle_ready();
    @(negedge clock);
    cnt_d = 0; cnt_i = 0;
    man_ready = 1'b1;
    #4;
    checks++; if (imem_ready !== 1'b0 || dmem_ready !== 1'b0) begin errors++; $display("FAIL idle_ready got i=%b d=%b exp 0/0", imem_ready, dmem_ready); end
    @(posedge clock); #1;
    checks++; if (dbg_state !== 2'd0 || bram_valid !== 1'b0) begin errors++; $display("FAIL idle_state got state=%0d valid=%b exp 0/0", dbg_state, bram_valid); end
    @(negedge clock); man_ready = 1'b0;
    repeat (2) @(negedge clock); #4;
    checks++; if (cnt_i != 0 || cnt_d != 0) begin errors++; $display("FAIL idle_pulses got i=%0d d=%0d exp 0/0", cnt_i, cnt_d); end
    model_en = 1'b1;
  endtask

  initial begin
    test_reset();
    test_dmem_read();
    test_dmem_write();
    test_back_to_back();
    test_starvation();
    test_reset_mid();
    test_idle_ready();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
